// File: rtl/feat_buf_arbiter.sv
// -----------------------------------------------------------------------------
// feat_buf_arbiter
//
// Shares one single-port feature buffer between NUM_REQ compute engines
// (global average pool, conv engine, DMA). A round-robin arbiter grants at
// most one access per cycle. The granted command is registered toward the
// buffer. An ID FIFO remembers who issued each outstanding read, so the
// in-order read responses can be steered back to their requesters.
//
// Ports
//   clk, rst             clock (rising edge) and asynchronous active-high reset
//   req_valid/we         per-requester request and write flag
//   req_addr/req_wdata   per-requester address/data; slice i = [i*W +: W]
//   req_ready            one-hot grant (combinational)
//   rsp_valid            one-hot read-response strobe (combinational)
//   rsp_data             read data broadcast to all requesters
//   buf_en/we/addr/wdata registered buffer command
//   buf_rdata/buf_rvalid buffer read return (latency >= 1, in order)
//   err_unexp            sticky: read data arrived with no read outstanding
// -----------------------------------------------------------------------------
module feat_buf_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 128,
  parameter int MAX_OUT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      buf_en,
  output logic                      buf_we,
  output logic [ADDR_W-1:0]         buf_addr,
  output logic [DATA_W-1:0]         buf_wdata,
  input  logic [DATA_W-1:0]         buf_rdata,
  input  logic                      buf_rvalid,
  output logic                      err_unexp
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  // State
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              buf_en_q, buf_en_d;
  logic              buf_we_q, buf_we_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_wdata_q, buf_wdata_d;
  logic              err_q, err_d;
  logic [ID_W-1:0]   id_mem_q [MAX_OUT];

  // Arbitration / FIFO control
  logic [NUM_REQ-1:0] eligible;
  logic               read_ok;
  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic               hi_found;
  logic [ID_W-1:0]    hi_idx;
  logic [ID_W-1:0]    lo_idx;
  logic               accept;
  logic               push;
  logic               pop;
  logic [ID_W-1:0]    head_id;

  // Per-requester views of the flattened address/data buses
  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // Reads use the registered count only; a pop in this same cycle gives no
  // credit, which keeps req_ready independent of buf_rvalid.
  assign read_ok  = (count_q < CNT_W'(MAX_OUT));
  assign eligible = req_valid & (req_we | {NUM_REQ{read_ok}});

  // Round-robin search: first eligible index at or above rr wins; if none,
  // wrap to the lowest eligible index. Scanning downward lets the last hit
  // be the lowest index in each class.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_idx = ID_W'(i);
        if (ID_W'(i) >= rr_q) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    grant_found = |eligible;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  assign accept    = grant_found & ~rst;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  assign push    = accept & ~req_we[grant_idx];
  assign pop     = buf_rvalid & (count_q != '0);
  assign head_id = id_mem_q[rd_ptr_q];

  assign rsp_data  = buf_rdata;
  assign rsp_valid = (pop & ~rst) ? (NUM_REQ'(1) << head_id) : '0;

  // Next-state logic
  always_comb begin
    rr_d        = rr_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    buf_en_d    = 1'b0;
    buf_we_d    = 1'b0;
    buf_addr_d  = buf_addr_q;
    buf_wdata_d = buf_wdata_q;
    err_d       = err_q | (buf_rvalid & (count_q == '0));

    if (accept) begin
      rr_d        = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      buf_en_d    = 1'b1;
      buf_we_d    = req_we[grant_idx];
      buf_addr_d  = addr_arr[grant_idx];
      buf_wdata_d = wdata_arr[grant_idx];
    end

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      buf_en_q    <= 1'b0;
      buf_we_q    <= 1'b0;
      buf_addr_q  <= '0;
      buf_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      buf_en_q    <= buf_en_d;
      buf_we_q    <= buf_we_d;
      buf_addr_q  <= buf_addr_d;
      buf_wdata_q <= buf_wdata_d;
      err_q       <= err_d;
    end
  end

  // NOTE: the ID storage has no reset; an entry is only read after it has been
  // written, because count gates every use of the head.
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem_q[wr_ptr_q] <= grant_idx;
    end
  end

  assign buf_en    = buf_en_q;
  assign buf_we    = buf_we_q;
  assign buf_addr  = buf_addr_q;
  assign buf_wdata = buf_wdata_q;
  assign err_unexp = err_q;

endmodule
